rv_decode_stage: RTL and testbench

//  Instruction decode stage sitting directly upstream of the 32x32 register file.

---
 rtl/rv_decode_stage_if.sv | 34 +++
 rtl/rv_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_rv_decode_stage.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// Handshake and decode-result bundle between fetch, rv_decode_stage and its consumers.
// The slave modport is the decode stage's view; master is the surrounding environment.
interface rv_decode_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;

    logic            wb_valid;
    logic [4:0]      wb_rd;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, rd_we, imm, fmt, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, rd_we, imm, fmt, illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32 decode stage with a one-entry registered output buffer.
// Define DECODE_SCOREBOARD_EN to add a register busy scoreboard that stalls on RAW/WAW hazards.
module rv_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input logic              clk,
    input logic              rst,
    rv_decode_stage_if.slave bus
);
    typedef enum logic [2:0] {
        FmtR       = 3'd0,
        FmtI       = 3'd1,
        FmtS       = 3'd2,
        FmtB       = 3'd3,
        FmtU       = 3'd4,
        FmtJ       = 3'd5,
        FmtIllegal = 3'd7
    } fmt_e;

    logic [31:0]        instr;
    fmt_e               dec_fmt;
    logic signed [31:0] dec_imm32;
    logic [XLEN-1:0]    dec_imm;
    logic [4:0]         dec_rd;
    logic [4:0]         dec_rs1;
    logic [4:0]         dec_rs2;
    logic               dec_rd_we;
    logic               stall;
    logic               capture;

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [4:0]         rs1_q, rs1_d;
    logic [4:0]         rs2_q, rs2_d;
    logic [4:0]         rd_q, rd_d;
    logic               rd_we_q, rd_we_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [2:0]         fmt_q, fmt_d;
    logic               illegal_q, illegal_d;

    assign instr   = bus.in_instr;
    assign dec_rd  = instr[11:7];
    assign dec_rs1 = instr[19:15];
    assign dec_rs2 = instr[24:20];

    always_comb begin
        dec_fmt = FmtIllegal;
        case (instr[6:0])
            7'b0110011:                         dec_fmt = FmtR;
            7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FmtI;
            7'b0100011:                         dec_fmt = FmtS;
            7'b1100011:                         dec_fmt = FmtB;
            7'b0110111, 7'b0010111:             dec_fmt = FmtU;
            7'b1101111:                         dec_fmt = FmtJ;
            default:                            dec_fmt = FmtIllegal;
        endcase
    end

    always_comb begin
        dec_imm32 = '0;
        case (dec_fmt)
            FmtI:    dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            FmtS:    dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB:    dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            FmtU:    dec_imm32 = {instr[31:12], 12'b0};
            FmtJ:    dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            default: dec_imm32 = '0;
        endcase
    end

    assign dec_imm   = XLEN'(dec_imm32);
    assign dec_rd_we = (dec_fmt inside {FmtR, FmtI, FmtU, FmtJ}) && (dec_rd != 5'd0);

`ifdef DECODE_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d;
    logic             use_rs1;
    logic             use_rs2;

    assign use_rs1 = !(dec_fmt inside {FmtU, FmtJ});
    assign use_rs2 = dec_fmt inside {FmtR, FmtS, FmtB};

    // Hazards are judged against registered busy bits, so a writeback frees the stall next cycle.
    assign stall = (use_rs1 && busy_q[dec_rs1]) ||
                   (use_rs2 && busy_q[dec_rs2]) ||
                   (dec_rd_we && busy_q[dec_rd]);

    always_comb begin
        busy_d = busy_q;
        if (bus.wb_valid) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle set of the same register wins.
        if (capture && dec_rd_we) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic [5:0] unused_cfg;

    assign stall      = 1'b0;
    assign unused_cfg = {bus.wb_valid, bus.wb_rd} ^ 6'(NREGS);
`endif

    assign bus.in_ready = rst && (!valid_q || bus.out_ready) && !stall;
    assign capture      = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;
        if (capture) begin
            valid_d   = 1'b1;
            pc_d      = bus.in_pc;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            rd_we_d   = dec_rd_we;
            imm_d     = dec_imm;
            fmt_d     = dec_fmt;
            illegal_d = (dec_fmt == FmtIllegal);
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            imm_q     <= '0;
            fmt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.rs1       = rs1_q;
    assign bus.rs2       = rs2_q;
    assign bus.rd        = rd_q;
    assign bus.rd_we     = rd_we_q;
    assign bus.imm       = imm_q;
    assign bus.fmt       = fmt_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed vectors, handshake sequences and a
// randomized run against an arithmetic decode model (scoreboard modelled when enabled).
module tb_rv_decode_stage;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(XLEN)) bus ();

    rv_decode_stage #(.XLEN(XLEN), .NREGS(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        illegal;
    } dec_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_busy;
    logic        m_valid;
    dec_t        m_dec;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] instr, input int fmt,
                                input logic [31:0] imm, input int rd, input int rs1,
                                input int rs2, input bit we, input bit ill);
        vec_t v;
        v.name  = name;
        v.instr = instr;
        v.exp   = '{fmt: 3'(fmt), imm: imm, rd: 5'(rd), rs1: 5'(rs1), rs2: 5'(rs2),
                    rd_we: we, illegal: ill};
        return v;
    endfunction

    // Immediates rebuilt with integer arithmetic rather than bit concatenation.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   v;
        d.rd  = w[11:7];
        d.rs1 = w[19:15];
        d.rs2 = w[24:20];
        case (w[6:0])
            7'h33:               d.fmt = 3'd0;
            7'h13, 7'h03, 7'h67: d.fmt = 3'd1;
            7'h23:               d.fmt = 3'd2;
            7'h63:               d.fmt = 3'd3;
            7'h37, 7'h17:        d.fmt = 3'd4;
            7'h6F:               d.fmt = 3'd5;
            default:             d.fmt = 3'd7;
        endcase
        case (d.fmt)
            3'd1:    v = $signed(w) >>> 20;
            3'd2:    v = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
            3'd3:    v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                         + int'(w[11:8]) * 2;
            3'd4:    v = int'(w & 32'hFFFF_F000);
            3'd5:    v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096
                         + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            default: v = 0;
        endcase
        d.imm     = 32'(v);
        d.illegal = (d.fmt == 3'd7);
        d.rd_we   = (d.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && (d.rd != 5'd0);
        return d;
    endfunction

    function automatic bit ref_stall(input dec_t d);
`ifdef DECODE_SCOREBOARD_EN
        bit r1 = !(d.fmt inside {3'd4, 3'd5}) && m_busy[d.rs1];
        bit r2 = (d.fmt inside {3'd0, 3'd2, 3'd3}) && m_busy[d.rs2];
        return r1 || r2 || (d.rd_we && m_busy[d.rd]);
`else
        return (d.fmt == 3'd6);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input dec_t e);
        chk({tag, "_fmt"}, 32'(bus.fmt), 32'(e.fmt));
        chk({tag, "_imm"}, bus.imm, e.imm);
        chk({tag, "_rd"}, 32'(bus.rd), 32'(e.rd));
        chk({tag, "_rs1"}, 32'(bus.rs1), 32'(e.rs1));
        chk({tag, "_rs2"}, 32'(bus.rs2), 32'(e.rs2));
        chk({tag, "_rd_we"}, 32'(bus.rd_we), 32'(e.rd_we));
        chk({tag, "_illegal"}, 32'(bus.illegal), 32'(e.illegal));
    endtask

    task automatic wb_clear(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input logic [31:0] pc);
        int k = 0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = v.instr;
        bus.in_pc     = pc;
        bus.out_ready = 1'b1;
        #1;
        while (bus.in_ready !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        chk({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({v.name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({v.name, "_out_pc"}, bus.out_pc, pc);
        chk_out(v.name, v.exp);
        wb_clear(v.exp.rd);
        chk({v.name, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[12];
        dec_t        zero_dec;
        dec_t        d;
        logic [6:0]  ops[10];
        logic [31:0] w;
        bit          m_rdy;

        vecs[0]  = mk("addi",   32'hFFF0_8293, 1, 32'hFFFF_FFFF,  5,  1, 31, 1, 0);
        vecs[1]  = mk("sw",     32'h0021_A423, 2, 32'h0000_0008,  8,  3,  2, 0, 0);
        vecs[2]  = mk("zero",   32'h0000_0000, 7, 32'h0000_0000,  0,  0,  0, 0, 1);
        vecs[3]  = mk("add",    32'h0052_8333, 0, 32'h0000_0000,  6,  5,  5, 1, 0);
        vecs[4]  = mk("lui",    32'h1234_50B7, 4, 32'h1234_5000,  1,  8,  3, 1, 0);
        vecs[5]  = mk("jal",    32'h0080_00EF, 5, 32'h0000_0008,  1,  0,  8, 1, 0);
        vecs[6]  = mk("beq",    32'hFE20_8EE3, 3, 32'hFFFF_FFFC, 29,  1,  2, 0, 0);
        vecs[7]  = mk("lw_x0",  32'h0041_2003, 1, 32'h0000_0004,  0,  2,  4, 0, 0);
        vecs[8]  = mk("sw_neg", 32'hFE53_2C23, 2, 32'hFFFF_FFF8, 24,  6,  5, 0, 0);
        vecs[9]  = mk("auipc",  32'hFFFF_F197, 4, 32'hFFFF_F000,  3, 31, 31, 1, 0);
        vecs[10] = mk("jalr",   32'h0002_80E7, 1, 32'h0000_0000,  1,  5,  0, 1, 0);
        vecs[11] = mk("ill_ff", 32'hFFFF_FFFF, 7, 32'h0000_0000, 31, 31, 31, 0, 1);
        zero_dec = '0;

        // Reset held with a pending instruction.
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF0_8293;
        bus.in_pc     = 32'h0000_1000;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk_out("rst", zero_dec);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (vecs[i]) apply_vec(vecs[i], 32'h0000_2000 + 32'(i) * 4);

        // Output held stable under backpressure, then replaced on the release cycle.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0050_0393;
        bus.in_pc     = 32'h0000_3000;
        #1;
        chk("bp_first_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_instr = 32'h1234_54B7;
        bus.in_pc    = 32'h0000_3004;
        #1;
        chk("bp_blocked", 32'(bus.in_ready), 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_rd", 32'(bus.rd), 32'd7);
            chk("bp_hold_imm", bus.imm, 32'd5);
            chk("bp_hold_pc", bus.out_pc, 32'h0000_3000);
            chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_rd", 32'(bus.rd), 32'd9);
        chk("b2b_imm", bus.imm, 32'h1234_5000);
        chk("b2b_fmt", 32'(bus.fmt), 32'd4);
        chk("b2b_pc", bus.out_pc, 32'h0000_3004);
        wb_clear(5'd7);
        wb_clear(5'd9);

        // Reset discards a held entry.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF0_8293;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_rd", 32'(bus.rd), 32'd0);
        rst           = 1'b1;
        bus.out_ready = 1'b1;

        // RAW hazard: ADDI x5 followed by ADD x6,x5,x5.
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFFF0_8293;
        tick();
        bus.in_instr = 32'h0052_8333;
        #1;
`ifdef DECODE_SCOREBOARD_EN
        chk("raw_stall", 32'(bus.in_ready), 32'd0);
        tick();
        chk("raw_stall2", 32'(bus.in_ready), 32'd0);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        #1;
        chk("raw_wb_cycle", 32'(bus.in_ready), 32'd0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        chk("raw_release", 32'(bus.in_ready), 32'd1);
`else
        chk("raw_no_stall", 32'(bus.in_ready), 32'd1);
`endif
        tick();
        bus.in_valid = 1'b0;
        chk("raw_add_valid", 32'(bus.out_valid), 32'd1);
        chk("raw_add_rd", 32'(bus.rd), 32'd6);
        chk("raw_add_fmt", 32'(bus.fmt), 32'd0);
        wb_clear(5'd6);
        wb_clear(5'd5);

        // Randomized run against the reference model.
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7B};
        rst = 1'b0;
        tick();
        rst     = 1'b1;
        m_valid = 1'b0;
        m_busy  = '0;
        m_dec   = '0;
        m_pc    = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            w        = $urandom;
            w[6:0]   = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            rst           = ($urandom_range(0, 99) != 0);
            bus.in_valid  = 1'($urandom);
            bus.in_instr  = w;
            bus.in_pc     = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wb_valid  = 1'($urandom);
            bus.wb_rd     = 5'($urandom_range(0, 7));
            #1;
            d     = ref_decode(w);
            m_rdy = rst && (!m_valid || bus.out_ready) && !ref_stall(d);
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(m_rdy));
            @(posedge clk);
            if (!rst) begin
                m_valid = 1'b0;
                m_dec   = '0;
                m_pc    = '0;
                m_busy  = '0;
            end else begin
                if (bus.wb_valid) m_busy[bus.wb_rd] = 1'b0;
                if (bus.in_valid && m_rdy) begin
                    m_valid = 1'b1;
                    m_dec   = d;
                    m_pc    = bus.in_pc;
                    if (d.rd_we) m_busy[d.rd] = 1'b1;
                end else if (bus.out_ready) begin
                    m_valid = 1'b0;
                end
            end
            #1;
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid || !rst) begin
                chk("rnd_out_pc", bus.out_pc, m_pc);
                chk_out("rnd", m_dec);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
